// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: round-robin arbiter that owns the select of an 8:1 bit mux.
// One requester holds the mux at a time. A grant ends when the owner asserts
// done, drops its request or (optionally) reaches MAX_HOLD cycles. Every
// release is followed by one idle cycle before the next arbitration.
// Optional feature macro: MUX_SEL_ARB_TIMEOUT_EN (hold counter + forced release).
module mux_sel_arbiter #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] sel,
   output logic [7:0] grant,
   output logic       busy,
   output logic       timeout
);

   localparam logic ST_IDLE  = 1'b0;
   localparam logic ST_GRANT = 1'b1;

   localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

   // Reject hold limits outside the supported range at elaboration time.
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_sel_arbiter: MAX_HOLD must be in 2..255");
   end

   logic       r_state;
   logic [2:0] r_last;
   logic [2:0] r_sel;
   logic [7:0] r_grant;
   logic       r_busy;

   logic       w_found;
   logic [2:0] w_idx;
   logic [2:0] w_cand;
   logic       w_rel_norm;
   logic       w_force;

   // Round-robin search: first set request starting at last+1, wrapping; the
   // previous owner (offset 8 == last) is considered last of all.
   always_comb begin
      w_found = 1'b0;
      w_idx   = r_last;
      w_cand  = r_last;
      for (int k = 8; k >= 1; k--) begin
         w_cand = r_last + 3'(k);
         if (req[w_cand]) begin
            w_found = 1'b1;
            w_idx   = w_cand;
         end
      end
   end

   // Normal release: owner is done or no longer requests its mux input.
   assign w_rel_norm = done | ~req[r_sel];

`ifdef MUX_SEL_ARB_TIMEOUT_EN
   logic [7:0] r_hold;
   logic       r_timeout;

   assign w_force = (r_hold == LP_MAX_HOLD);
   assign timeout = r_timeout;

   // Hold counter: 1 on the first grant cycle, cleared on any release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= 8'd0;
      end else if (r_state == ST_IDLE) begin
         r_hold <= w_found ? 8'd1 : 8'd0;
      end else if (w_rel_norm || w_force) begin
         r_hold <= 8'd0;
      end else begin
         r_hold <= r_hold + 8'd1;
      end
   end

   // Timeout pulse only when the limit, not the owner, ends the grant.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= (r_state == ST_GRANT) && !w_rel_norm && w_force;
      end
   end
`else
   assign w_force = 1'b0;
   assign timeout = 1'b0;
`endif

   // Arbitration FSM: grant/sel/busy/pointer updates; sel holds while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_last  <= 3'd7;
         r_sel   <= 3'd0;
         r_grant <= 8'h00;
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_state <= ST_GRANT;
                  r_last  <= w_idx;
                  r_sel   <= w_idx;
                  r_grant <= 8'h01 << w_idx;
                  r_busy  <= 1'b1;
               end
            end
            default: begin
               if (w_rel_norm || w_force) begin
                  r_state <= ST_IDLE;
                  r_grant <= 8'h00;
                  r_busy  <= 1'b0;
               end
            end
         endcase
      end
   end

   assign sel   = r_sel;
   assign grant = r_grant;
   assign busy  = r_busy;

endmodule
